// File: rtl/conv_window_5x5_if.sv
// Pixel-stream-in / window-out bundle for the 5x5 sliding-window generator.
// The producer drives pixels; the window block returns registered windows and strobes.
interface conv_window_5x5_if #(
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic [WIDTH-1:0]       in_pixel;
    logic [24:0][WIDTH-1:0] win;
    logic                   win_valid;
    logic                   frame_done;

    modport master (
        output in_valid, in_pixel,
        input  win, win_valid, frame_done
    );

    modport slave (
        input  in_valid, in_pixel,
        output win, win_valid, frame_done
    );
endinterface

// File: rtl/conv_window_5x5.sv
// Streaming 5x5 window generator: raster pixels in, every fully-populated 5x5 window out
// one cycle later, with no padding at the image borders.
module conv_window_5x5 #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic             clk,
    input  logic             rst,
    conv_window_5x5_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int LD = IMG_W - 1;
    localparam int PW = $clog2(LD);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [PW-1:0] ptr;
    logic          accept;
    logic          last_col;
    logic          last_row;
    logic          window_ready;

    logic [WIDTH-1:0]      line_mem [4][LD];
    logic [3:0][WIDTH-1:0] line_out;

    assign accept       = bus.in_valid;
    assign last_col     = (col == CW'(IMG_W - 1));
    assign last_row     = (row == RW'(IMG_H - 1));
    assign window_ready = (row >= RW'(4)) && (col >= CW'(4));

    // Pixel coordinates and the shared line-FIFO pointer; all advance only on accepted pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
            ptr <= '0;
        end else if (accept) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples
            // the pre-edge values of the others, independent of statement order.
            col <= last_col ? '0 : col + 1'b1;
            if (last_col) row <= last_row ? '0 : row + 1'b1;
            ptr <= (ptr == PW'(LD - 1)) ? '0 : ptr + 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) line_out[k] = line_mem[k][ptr];
    end

    // Each line FIFO is fed by the rightmost pixel of the window row below it. That pixel
    // entered one accept earlier, so IMG_W-1 entries give exactly one image row of delay.
    // NOTE: line storage has no reset; stale contents are never exposed because windows are
    // only flagged valid once four fresh rows of the current frame have passed through.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            for (int k = 0; k < 4; k++) line_mem[k][ptr] <= bus.win[(k + 1) * 5 + 4];
        end
    end

    // Window shift register: every row moves one column left, new column enters on the right.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.win        <= '0;
            bus.win_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.win_valid  <= accept && window_ready;
            bus.frame_done <= accept && last_row && last_col;
            if (accept) begin
                for (int r = 0; r < 5; r++) begin
                    for (int c = 0; c < 4; c++) bus.win[r * 5 + c] <= bus.win[r * 5 + c + 1];
                end
                for (int r = 0; r < 4; r++) bus.win[r * 5 + 4] <= line_out[r];
                bus.win[24] <= bus.in_pixel;
            end
        end
    end
endmodule
